gpu_warp_scheduler: RTL
=======================

Name: gpu_warp_scheduler

Overview:
- Upstream stage of gpu_warp; owns one program counter and one lifecycle state per resident warp.
- Selects a ready warp round-robin and presents its warp id and PC to gpu_warp over a valid/ready issue handshake.
- Retires completions from gpu_warp, which either advance the PC, redirect it for a taken branch, or exit the warp.
- Allows at most one instruction in flight per warp.

Parameters:
- NUM_WARPS, 4, number of resident warps; power of two, at least 2.
- WID_W, 2, warp id width; equals log2(NUM_WARPS).
- PC_W, 16, program counter width; matches the gpu_warp pc port.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- launch_valid  input  1  request to start a warp.
- launch_warp  input  WID_W  warp id to start.
- launch_pc  input  PC_W  start PC.
- launch_ready  output  1  combinational; high when launch_warp is IDLE.
- issue_valid  output  1  registered; issue_warp and issue_pc are valid.
- issue_warp  output  WID_W  issued warp id.
- issue_pc  output  PC_W  issued PC; drives the pc input of gpu_warp.
- issue_ready  input  1  gpu_warp accepts the issue.
- complete_valid  input  1  an in-flight instruction has finished.
- complete_warp  input  WID_W  id of the completing warp.
- complete_redirect  input  1  branch taken; load complete_target.
- complete_target  input  PC_W  branch target PC.
- complete_exit  input  1  warp terminates.
- warp_active  output  NUM_WARPS  per-warp flag; high when the warp is not IDLE.
- busy  output  1  OR of warp_active, or issue_valid.
- err_sticky  output  1  set by an illegal completion; cleared only by reset.

Behaviour:
- Per-warp state machine has three states: IDLE, READY, INFLIGHT.
- Reset (asynchronous, rst_n low) takes effect immediately and applies even mid-operation; any in-flight work is discarded:
  - every warp goes to IDLE and every PC to 0;
  - issue_valid, issue_warp, issue_pc, err_sticky all go to 0;
  - the round-robin pointer rr_ptr goes to 0.
- Launch: on a clock edge where launch_valid and launch_ready are both high, the warp moves IDLE->READY and pc[w] loads launch_pc. A launch to a non-IDLE warp is ignored and has no side effects.
- Issue selection is evaluated every edge on which either issue_valid is low or issue_valid and issue_ready are both high:
  - Scan rr_ptr, rr_ptr+1, ... modulo NUM_WARPS.
  - Pick the first READY warp. A warp handing off on this same edge is treated as INFLIGHT and is not picked.
  - If one is found: issue_valid goes to 1, issue_warp and issue_pc load that warp's id and PC, and rr_ptr loads (picked id + 1) modulo NUM_WARPS.
  - If none is found, issue_valid goes to 0.
- Handshake:
  - On an edge with issue_valid and issue_ready both high, issue_warp moves READY->INFLIGHT.
  - While issue_valid is high and issue_ready is low, issue_warp and issue_pc hold stable and the warp stays READY.
- Latency: a launch at edge t makes issue_valid high after edge t+1 when no other warp is READY. A back-to-back handshake every cycle is supported when enough warps are READY.
- Completion applies on an edge with complete_valid high and complete_warp INFLIGHT. Priority, highest first:
  - complete_exit: warp goes to IDLE.
  - complete_redirect: pc loads complete_target, warp goes to READY.
  - neither: pc loads pc + 1, wrapping modulo 2^PC_W (0xFFFF -> 0x0000), warp goes to READY.
- Illegal completion: complete_valid high for a warp that is not INFLIGHT sets err_sticky and leaves that warp's state and PC unchanged.
- Simultaneous events:
  - Launch, handshake and completion on distinct warps in the same edge all take effect.
  - A completion is not eligible for issue on the edge where it occurs; the earliest that warp can issue is the next edge.
  - A launch and a completion targeting the same warp cannot both be legal; the completion rule governs.
- Outputs busy and warp_active are derived combinationally from registered state.

Test Plan:
- Reset then launch warp 2 at PC 0x0010 -> launch_ready=1. issue_valid rises one edge later with issue_warp=2, issue_pc=0x0010. warp_active=4'b0100.
- Launch warps 0, 1, 3 at 0x0100, 0x0200, 0x0300, with issue_ready held at 1 -> issue order 0, 1, 3. Each warp issues once and stays INFLIGHT until completed.
- Warp 1 INFLIGHT at 0x0200; complete with no redirect -> next issue_pc=0x0201. Then complete with redirect, target 0x0040 -> next issue_pc=0x0040. PC 0xFFFF completed -> 0x0000.
- Hold issue_ready=0 for 3 cycles with warp 0 presented -> issue_warp and issue_pc are unchanged each cycle. A launch to warp 0 during this is ignored (launch_ready=0).
- Complete warp 3 with exit=1 -> warp_active[3]=0. A completion for the now-IDLE warp 3 sets err_sticky=1, which persists until reset.
- Deassert rst_n asynchronously mid-issue -> issue_valid, warp_active and err_sticky clear immediately. After release, the first launch issues normally starting from warp 0 priority.

Source files
------------

// File: rtl/gpu_warp_scheduler.sv
// gpu_warp_scheduler: per-warp PC and lifecycle tracking with round-robin issue to gpu_warp.
// At most one instruction is in flight per warp; completions advance, redirect or retire the warp.
module gpu_warp_scheduler #(
  parameter int NUM_WARPS = 4,
  parameter int WID_W = 2,
  parameter int PC_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 launch_valid,
  input  logic [WID_W-1:0]     launch_warp,
  input  logic [PC_W-1:0]      launch_pc,
  output logic                 launch_ready,
  output logic                 issue_valid,
  output logic [WID_W-1:0]     issue_warp,
  output logic [PC_W-1:0]      issue_pc,
  input  logic                 issue_ready,
  input  logic                 complete_valid,
  input  logic [WID_W-1:0]     complete_warp,
  input  logic                 complete_redirect,
  input  logic [PC_W-1:0]      complete_target,
  input  logic                 complete_exit,
  output logic [NUM_WARPS-1:0] warp_active,
  output logic                 busy,
  output logic                 err_sticky
);
  typedef enum logic [1:0] {IDLE, READY, INFLIGHT} wstate_t;
  wstate_t          state_q [NUM_WARPS];
  wstate_t          state_d [NUM_WARPS];
  logic [PC_W-1:0]  pc_q [NUM_WARPS];
  logic [PC_W-1:0]  pc_d [NUM_WARPS];
  logic             issue_valid_q, issue_valid_d;
  logic [WID_W-1:0] issue_warp_q, issue_warp_d;
  logic [PC_W-1:0]  issue_pc_q, issue_pc_d;
  logic [WID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             err_q, err_d;
  logic             hs, found, launch_go, complete_ok;
  logic [WID_W-1:0] pick, cand;

  assign hs          = issue_valid_q && issue_ready;
  assign launch_ready = state_q[launch_warp] == IDLE;
  assign complete_ok = complete_valid && state_q[complete_warp] == INFLIGHT;
  // a completion aimed at the same warp overrides a launch
  assign launch_go   = launch_valid && launch_ready && !(complete_valid && complete_warp == launch_warp);

  always_comb begin
    found = 1'b0;
    pick  = rr_ptr_q;
    cand  = rr_ptr_q;
    for (int k = 0; k < NUM_WARPS; k++) begin
      cand = rr_ptr_q + WID_W'(k);
      if (!found && state_q[cand] == READY && !(hs && issue_warp_q == cand)) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    err_d         = err_q || (complete_valid && !complete_ok);
    issue_valid_d = issue_valid_q;
    issue_warp_d  = issue_warp_q;
    issue_pc_d    = issue_pc_q;
    rr_ptr_d      = rr_ptr_q;
    if (launch_go) begin
      state_d[launch_warp] = READY;
      pc_d[launch_warp]    = launch_pc;
    end
    if (hs)
      state_d[issue_warp_q] = INFLIGHT;
    if (complete_ok) begin
      state_d[complete_warp] = complete_exit ? IDLE : READY;
      pc_d[complete_warp]    = complete_exit ? pc_q[complete_warp]
                             : complete_redirect ? complete_target
                             : pc_q[complete_warp] + PC_W'(1);
    end
    if (!issue_valid_q || hs) begin
      issue_valid_d = found;
      issue_warp_d  = found ? pick : issue_warp_q;
      issue_pc_d    = found ? pc_q[pick] : issue_pc_q;
      rr_ptr_d      = found ? pick + WID_W'(1) : rr_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        state_q[i] <= IDLE;
        pc_q[i]    <= '0;
      end
      issue_valid_q <= 1'b0;
      issue_warp_q  <= '0;
      issue_pc_q    <= '0;
      rr_ptr_q      <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      issue_valid_q <= issue_valid_d;
      issue_warp_q  <= issue_warp_d;
      issue_pc_q    <= issue_pc_d;
      rr_ptr_q      <= rr_ptr_d;
      err_q         <= err_d;
    end
  end

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_act
    assign warp_active[g] = state_q[g] != IDLE;
  end

  assign issue_valid = issue_valid_q;
  assign issue_warp  = issue_warp_q;
  assign issue_pc    = issue_pc_q;
  assign err_sticky  = err_q;
  assign busy        = |warp_active || issue_valid_q;
endmodule
